// File: rtl/fetch_pkg.sv
// Shared fetch/branch types: predictions, resolutions and queue entries.
// Holds the branch_res_queue entry layout and its mispredict rule.
package fetch_pkg;

    localparam int XLEN      = 32;
    localparam int BRQ_DEPTH = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } prediction_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            mispredict;
    } resolution_t;

    typedef struct packed {
        logic            valid;
        logic            resolved;
        prediction_t     pred;
        logic            act_taken;
        logic [XLEN-1:0] act_target;
        logic            mispredict;
    } brq_entry_t;

    // A taken branch must also match the predicted target.
    function automatic logic brq_mispredict(
        input prediction_t     pred,
        input logic            taken,
        input logic [XLEN-1:0] target
    );
        return (taken != pred.taken) || (taken && (target != pred.target));
    endfunction

endpackage

// File: rtl/branch_res_queue.sv
// In-order in-flight branch queue feeding commit-time BPU updates.
// Optional commit/mispredict counters built only with BRQ_STATS_EN.
module branch_res_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              pred_valid_i,
    input  prediction_t       pred_i,
    output logic              pred_ready_o,
    output logic [TAG_W-1:0]  pred_tag_o,
    input  logic              exe_valid_i,
    input  logic [TAG_W-1:0]  exe_tag_i,
    input  logic              exe_taken_i,
    input  logic [XLEN-1:0]   exe_target_i,
    input  logic              commit_i,
    output logic              comm_res_valid_o,
    output resolution_t       comm_res_o,
    output logic [31:0]       stat_commits_o,
    output logic [31:0]       stat_mispred_o
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    brq_entry_t       r_q [DEPTH];
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;
    logic             r_res_valid;
    resolution_t      r_res;

    logic w_ready;
    logic w_push;
    logic w_exe_wr;
    logic w_pop;

    assign w_ready  = (r_count != FULL);
    assign w_push   = pred_valid_i && w_ready && !flush_i;
    assign w_exe_wr = exe_valid_i && r_q[exe_tag_i].valid
                      && !r_q[exe_tag_i].resolved && !flush_i;
    assign w_pop    = commit_i && r_q[r_head].valid
                      && r_q[r_head].resolved && !flush_i;

    assign pred_ready_o     = w_ready;
    assign pred_tag_o       = r_tail;
    assign comm_res_valid_o = r_res_valid;
    assign comm_res_o       = r_res;

    // Push, exe write and pop never touch the same entry in one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
        end else begin
            r_res_valid <= w_pop;
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_q[i].valid <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_q[r_tail].valid      <= 1'b1;
                    r_q[r_tail].resolved   <= 1'b0;
                    r_q[r_tail].pred       <= pred_i;
                    r_q[r_tail].mispredict <= 1'b0;
                    r_tail                 <= r_tail + TAG_W'(1);
                end
                if (w_exe_wr) begin
                    r_q[exe_tag_i].resolved   <= 1'b1;
                    r_q[exe_tag_i].act_taken  <= exe_taken_i;
                    r_q[exe_tag_i].act_target <= exe_target_i;
                    r_q[exe_tag_i].mispredict <= brq_mispredict(
                        r_q[exe_tag_i].pred, exe_taken_i, exe_target_i);
                end
                if (w_pop) begin
                    r_q[r_head].valid <= 1'b0;
                    r_head            <= r_head + TAG_W'(1);
                    r_res.pc          <= r_q[r_head].pred.pc;
                    r_res.target      <= r_q[r_head].act_target;
                    r_res.taken       <= r_q[r_head].act_taken;
                    r_res.mispredict  <= r_q[r_head].mispredict;
                end
                r_count <= r_count + (TAG_W+1)'(w_push)
                                   - (TAG_W+1)'(w_pop);
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [31:0] r_commits;
    logic [31:0] r_mispred;

    // Saturating counters; flush leaves them alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_commits <= '0;
            r_mispred <= '0;
        end else if (w_pop) begin
            if (r_commits != 32'hFFFF_FFFF) begin
                r_commits <= r_commits + 32'd1;
            end
            if (r_q[r_head].mispredict && (r_mispred != 32'hFFFF_FFFF)) begin
                r_mispred <= r_mispred + 32'd1;
            end
        end
    end

    assign stat_commits_o = r_commits;
    assign stat_mispred_o = r_mispred;
`else
    assign stat_commits_o = '0;
    assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_branch_res_queue.sv
// Self-checking bench for branch_res_queue: directed steps then random
// traffic against an allocation-order queue model.
module tb_branch_res_queue;
    import fetch_pkg::*;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        pv;
    prediction_t pp;
    logic        ready;
    logic [2:0]  tag;
    logic        ev;
    logic [2:0]  etag;
    logic        et;
    logic [31:0] etg;
    logic        cm;
    logic        rv;
    resolution_t res;
    logic [31:0] sc;
    logic [31:0] sm;

    int checks   = 0;
    int failures = 0;

    int          fifo[$];
    int          nxt;
    prediction_t m_pred[D];
    bit          m_done[D];
    bit          m_taken[D];
    logic [31:0] m_tgt[D];
    bit          m_mp[D];
    bit          e_valid;
    resolution_t e_res;
    int          e_commits;
    int          e_mis;

    always #5 clk = ~clk;

    branch_res_queue dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .pred_valid_i     (pv),
        .pred_i           (pp),
        .pred_ready_o     (ready),
        .pred_tag_o       (tag),
        .exe_valid_i      (ev),
        .exe_tag_i        (etag),
        .exe_taken_i      (et),
        .exe_target_i     (etg),
        .commit_i         (cm),
        .comm_res_valid_o (rv),
        .comm_res_o       (res),
        .stat_commits_o   (sc),
        .stat_mispred_o   (sm)
    );

    task automatic chk(input string name, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit in_q(input int t);
        foreach (fifo[i]) if (fifo[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        fifo.delete();
        nxt       = 0;
        e_valid   = 1'b0;
        e_res     = '0;
        e_commits = 0;
        e_mis     = 0;
        for (int i = 0; i < D; i++) m_done[i] = 1'b0;
    endtask

    task automatic check_all();
        chk("pred_ready", ready, fifo.size() != D);
        chk("pred_tag", tag, nxt);
        chk("res_valid", rv, e_valid);
        chk("res", res, e_res);
`ifdef BRQ_STATS_EN
        chk("stat_commits", sc, e_commits);
        chk("stat_mispred", sm, e_mis);
`else
        chk("stat_commits", sc, 0);
        chk("stat_mispred", sm, 0);
`endif
    endtask

    // Reference behaviour for one rising edge, from the pre-edge inputs.
    task automatic model_step();
        bit pop;
        bit push;
        int h;
        int t;
        e_valid = 1'b0;
        if (flush) begin
            fifo.delete();
            nxt = 0;
        end else begin
            pop  = cm && fifo.size() > 0 && m_done[fifo[0]];
            push = pv && fifo.size() < D;
            t    = int'(etag);
            if (ev && in_q(t) && !m_done[t]) begin
                m_done[t]  = 1'b1;
                m_taken[t] = et;
                m_tgt[t]   = etg;
                m_mp[t]    = (et != m_pred[t].taken)
                             || (et && etg != m_pred[t].target);
            end
            if (push) begin
                m_pred[nxt] = pp;
                m_done[nxt] = 1'b0;
                fifo.push_back(nxt);
                nxt = (nxt + 1) % D;
            end
            if (pop) begin
                h                = fifo.pop_front();
                e_valid          = 1'b1;
                e_res.pc         = m_pred[h].pc;
                e_res.target     = m_tgt[h];
                e_res.taken      = m_taken[h];
                e_res.mispredict = m_mp[h];
                e_commits++;
                if (m_mp[h]) e_mis++;
            end
        end
    endtask

    task automatic cyc(input bit i_pv, input logic [31:0] pc,
                       input bit ptk, input logic [31:0] ptg,
                       input bit i_ev, input int i_tag, input bit i_et,
                       input logic [31:0] i_etg, input bit i_cm,
                       input bit i_fl);
        pv        = i_pv;
        pp.pc     = pc;
        pp.taken  = ptk;
        pp.target = ptg;
        ev        = i_ev;
        etag      = 3'(i_tag);
        et        = i_et;
        etg       = i_etg;
        cm        = i_cm;
        flush     = i_fl;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input bit tk,
                        input logic [31:0] tg);
        cyc(1, pc, tk, tg, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic exe(input int t, input bit tk, input logic [31:0] tg,
                       input bit c);
        cyc(0, 0, 0, 0, 1, t, tk, tg, c, 0);
    endtask

    task automatic commit();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic do_reset();
        pv = 0; ev = 0; cm = 0; flush = 0;
        rst = 1'b1;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit    mis;
        int    r;
        logic [31:0] tgs [2];
        tgs[0] = 32'h200;
        tgs[1] = 32'h240;
        pv = 0; pp = '0; ev = 0; etag = 0; et = 0; etg = 0;
        cm = 0; flush = 0; rst = 1'b0;
        #2;
        do_reset();

        // one branch: pulse three cycles after the push
        push(32'h100, 1, 32'h200);
        exe(0, 1, 32'h200, 0);
        commit();
        chk("one_branch_mp", res.mispredict, 1'b0);
        idle();

        // target mismatch
        push(32'h300, 1, 32'h200);
        exe(1, 1, 32'h240, 0);
        commit();
        chk("tgt_mismatch_mp", res.mispredict, 1'b1);
        chk("tgt_mismatch_tgt", res.target, 32'h240);
        idle();

        // out-of-order resolve
        do_reset();
        push(32'h10, 0, 32'h0);
        push(32'h14, 0, 32'h0);
        push(32'h18, 0, 32'h0);
        exe(2, 0, 32'h0, 1);
        exe(1, 1, 32'h80, 1);
        exe(0, 0, 32'h0, 1);
        commit();
        chk("ooo_pc0", res.pc, 32'h10);
        commit();
        chk("ooo_pc1", res.pc, 32'h14);
        commit();
        chk("ooo_pc2", res.pc, 32'h18);
        idle();

        // full and wrap
        do_reset();
        for (int i = 0; i < D; i++) push(32'h1000 + 32'(i * 4), 1, 32'h40);
        chk("full_ready", ready, 1'b0);
        exe(0, 1, 32'h40, 0);
        cyc(1, 32'h2000, 0, 0, 1, 1, 0, 0, 1, 0);
        chk("full_blocked_tag", tag, 3'd0);
        cyc(1, 32'h2004, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("wrap_tag", tag, 3'd1);
        push(32'h2008, 0, 0);
        chk("refull_ready", ready, 1'b0);

        // flush with pending entries
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h500 + 32'(i * 4), 0, 0);
        exe(1, 1, 32'h44, 0);
        exe(3, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("flush_ready", ready, 1'b1);
        exe(1, 1, 32'h44, 1);
        commit();
        push(32'h600, 0, 0);
        exe(3, 0, 32'h0, 1);
        commit();
        chk("flush_nopulse", rv, 1'b0);

        // statistics: 10 commits, 3 mispredicted
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mis = (i == 2 || i == 5 || i == 7);
            r   = nxt;
            push(32'h700 + 32'(i * 4), 1, 32'h200);
            exe(r, !mis, 32'h200, 0);
            commit();
        end
        idle();
`ifdef BRQ_STATS_EN
        chk("stats_commits10", sc, 32'd10);
        chk("stats_mispred3", sm, 32'd3);
`else
        chk("stats_commits_off", sc, 32'd0);
        chk("stats_mispred_off", sm, 32'd0);
`endif

        // asynchronous reset between edges
        push(32'h900, 1, 32'h200);
        exe(0, 1, 32'h200, 1);
        rst = 1'b1;
        #1;
        model_clear();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // random traffic
        for (int n = 0; n < 800; n++) begin
            if (fifo.size() > 0 && $urandom_range(0, 3) != 0)
                r = fifo[$urandom_range(0, fifo.size() - 1)];
            else
                r = $urandom_range(0, D - 1);
            cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                tgs[$urandom_range(0, 1)],
                $urandom_range(0, 2) != 0, r, $urandom_range(0, 1),
                tgs[$urandom_range(0, 1)],
                $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_res_queue.md
# branch_res_queue

In-order tracking queue for in-flight branches. It sits between fetch, the branch execution unit and commit, and feeds the BPU its commit-time update stream. Fetch allocates one entry per predicted branch and carries the returned tag downstream. The branch unit writes the actual outcome by tag, in any order. Entries retire in order on `commit_i` and are emitted as a registered `resolution_t` with the `mispredict` flag computed against the stored prediction.

## Interface
- `DEPTH`, 8: number of entries; must be a power of 2, at least 2.
- `TAG_W`, `$clog2(DEPTH)`: tag width. Derived; do not override.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `flush_i`  in  1  synchronous pipeline flush.
- `pred_valid_i`  in  1  fetch requests allocation of an entry.
- `pred_i`  in  `prediction_t`  predicted `pc`, `taken`, `target`.
- `pred_ready_o`  out  1  an entry is free.
- `pred_tag_o`  out  `TAG_W`  tag of the entry allocated on this handshake (the tail index).
- `exe_valid_i`  in  1  branch outcome valid.
- `exe_tag_i`  in  `TAG_W`  tag of the resolved branch.
- `exe_taken_i`  in  1  actual direction.
- `exe_target_i`  in  `XLEN`  actual target.
- `commit_i`  in  1  commit permits retiring the head branch.
- `comm_res_valid_o`  out  1  resolution valid, one-cycle pulse.
- `comm_res_o`  out  `resolution_t`  `pc`, `target`, `taken`, `mispredict`.
- `stat_commits_o`  out  32  number of committed branches.
- `stat_mispred_o`  out  32  number of committed mispredicts.

## Operation
- Each entry holds `valid`, `resolved`, the prediction, the actual taken flag, the actual target and `mispredict`.
- Head pointer, tail pointer and a count of width `TAG_W+1`. Pointers wrap modulo `DEPTH`.
- **Push:**
  - Condition: `pred_valid_i && pred_ready_o && !flush_i`.
  - Writes the tail entry with `valid=1`, `resolved=0`, increments the tail pointer.
  - `pred_ready_o = (count != DEPTH)`, registered-state based. There is no bypass, so a full queue stays not-ready even in a cycle where it pops.
- **Exe write:**
  - Condition: `exe_valid_i && entry[exe_tag_i].valid && !entry.resolved && !flush_i`.
  - Stores `taken` and `target`, and sets `resolved=1`.
  - `mispredict = (exe_taken_i != pred.taken) || (exe_taken_i && exe_target_i != pred.target)`.
  - A write to an invalid entry or an already-resolved entry is ignored.
- **Pop:**
  - Condition: `commit_i && head.valid && head.resolved && !flush_i`.
  - Clears the head `valid` bit, increments the head pointer, and loads the output register.
  - `commit_i` with an unresolved or empty head has no effect.
- **Simultaneous events:**
  - Push, exe write and pop in the same cycle are all legal; count changes by the net amount.
  - An exe write to the head entry in cycle N makes it poppable in N+1 at the earliest (`resolved` is registered).
- **Flush:**
  - Clears every `valid` bit; head, tail and count go to 0.
  - Blocks push, exe write and pop in that cycle.
  - A resolution already visible on the outputs in the flush cycle is not suppressed.
- **Arithmetic:** `target` fields are full `XLEN`. `comm_res_o.pc` and `comm_res_o.target` are passed through unchanged.

## Timing
- **Reset values:** `pred_ready_o=1`, `pred_tag_o=0`, `comm_res_valid_o=0`, `comm_res_o='0`, stats = 0, all entries invalid.
- **Latency:**
  - Push at N → earliest exe write at N+1 → earliest pop at N+2 → `comm_res_valid_o` high in N+3 for exactly one cycle.
- **Output behaviour:**
  - `comm_res_o` holds its last value while valid is low.
  - No ready/backpressure exists on the output; the consumer must accept every pulse.
- **Reset mid-operation:** all state clears immediately (asynchronous). Outputs return to reset values without waiting for a clock edge.

## Configuration
- `BRQ_STATS_EN` defined:
  - `stat_commits_o` increments on each pop.
  - `stat_mispred_o` increments on each pop whose entry has `mispredict=1`.
  - Both counters saturate at `32'hFFFF_FFFF`.
  - Cleared by reset only; unaffected by flush.
- `BRQ_STATS_EN` undefined: no counter registers are built and both stat ports are tied to 0.

## Structure
- `brq_entry_t`, `BRQ_DEPTH` (default 8) and a `brq_mispredict()` function go in `fetch_pkg`, next to `prediction_t` and `resolution_t`.
- Single module with no sub-module. The entry array and pointers are small enough to keep inline.

## Test plan
- **Reset, then one branch:** push pc=0x100 with pred taken=1, target=0x200; exe tag 0 with taken=1, target=0x200; assert commit → one pulse with `mispredict=0` exactly 3 cycles after the push.
- **Target mismatch:** pred taken=1, target=0x200; exe taken=1, target=0x240 → `mispredict=1`, `comm_res_o.target=0x240`.
- **Out-of-order resolve:** push tags 0,1,2; exe writes tags 2, 1, 0 with commit held high → pulses arrive in tag order 0,1,2 on consecutive cycles.
- **Full and wrap:** push 8 with DEPTH=8 → `pred_ready_o=0`. Pop and push in the same cycle → count stays 7 then 8, and the next tag wraps to 0.
- **Flush with pending entries:** 5 entries, 2 resolved, flush → count 0, `pred_ready_o=1`, no pulse. A subsequent exe write to an old tag is ignored.
- **Stats with `BRQ_STATS_EN`:** 10 commits, 3 of them mispredicted → `stat_commits_o=10`, `stat_mispred_o=3`. Without the macro, both read 0.
